// File: rtl/draw_sequencer.sv
// Serves latched redraw requests one client at a time over the start/done handshake and
// forwards the served client's x/y/colour stream to the VGA adapter write port.
module draw_sequencer #(
    parameter int NUM_CLIENTS = 4,
    parameter int XW          = 9,
    parameter int YW          = 9,
    parameter int CW          = 3,
    parameter int TIMEOUT     = 20000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_CLIENTS-1:0]    req,
    output logic [NUM_CLIENTS-1:0]    start,
    input  logic [NUM_CLIENTS-1:0]    client_done,
    input  logic [NUM_CLIENTS*XW-1:0] client_x,
    input  logic [NUM_CLIENTS*YW-1:0] client_y,
    input  logic [NUM_CLIENTS*CW-1:0] client_colour,
    output logic [XW-1:0]             vga_x,
    output logic [YW-1:0]             vga_y,
    output logic [CW-1:0]             vga_colour,
    output logic                      vga_plot,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      timeout_err
);

    localparam int SEL_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;
    logic [NUM_CLIENTS-1:0] pending_q, pending_d;
    logic [NUM_CLIENTS-1:0] start_q, start_d;
    logic [XW-1:0]          vga_x_q, vga_x_d;
    logic [YW-1:0]          vga_y_q, vga_y_d;
    logic [CW-1:0]          vga_colour_q, vga_colour_d;
    logic                   vga_plot_q, vga_plot_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [SEL_W-1:0]       first_idx;
    logic [NUM_CLIENTS-1:0] grant_clr;
    logic [XW-1:0]          cur_x;
    logic [YW-1:0]          cur_y;
    logic [CW-1:0]          cur_colour;
    logic                   cur_done;

    // Fixed priority: scanning downwards leaves the lowest pending index selected.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_idx = SEL_W'(i);
            end
        end
    end

    // Only the selected client's fields reach the datapath; all other clients are ignored.
    always_comb begin
        cur_x      = '0;
        cur_y      = '0;
        cur_colour = '0;
        cur_done   = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_x      = client_x[i*XW +: XW];
                cur_y      = client_y[i*YW +: YW];
                cur_colour = client_colour[i*CW +: CW];
                cur_done   = client_done[i];
            end
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or a safe constant) so no path through the case infers a latch.
        state_d       = state_q;
        sel_d         = sel_q;
        run_cnt_d     = run_cnt_q;
        start_d       = start_q;
        vga_x_d       = vga_x_q;
        vga_y_d       = vga_y_q;
        vga_colour_d  = vga_colour_q;
        vga_plot_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        grant_clr     = '0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    sel_d     = first_idx;
                    grant_clr = NUM_CLIENTS'(1) << first_idx;
                    start_d   = NUM_CLIENTS'(1) << first_idx;
                    run_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end

            S_RUN: begin
                run_cnt_d    = run_cnt_q + CNT_W'(1);
                vga_x_d      = cur_x;
                vga_y_d      = cur_y;
                vga_colour_d = cur_colour;
                // The first RUN cycle carries stale coordinates from before start rose.
                vga_plot_d   = (run_cnt_q != '0) && !cur_done;
                if (cur_done) begin
                    start_d = '0;
                    state_d = S_RELEASE;
                end else if (run_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    start_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_RELEASE;
                end
            end

            S_RELEASE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                start_d = '0;
            end
        endcase

        // A request in the grant cycle survives the clear, so that client is served again.
        pending_d = (pending_q & ~grant_clr) | req;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            run_cnt_q     <= '0;
            pending_q     <= '0;
            start_q       <= '0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_plot_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            sel_q         <= sel_d;
            run_cnt_q     <= run_cnt_d;
            pending_q     <= pending_d;
            start_q       <= start_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_colour_q  <= vga_colour_d;
            vga_plot_q    <= vga_plot_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign start       = start_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = (state_q == S_RELEASE) && (pending_q == '0);

    a_start_onehot0: assert property (@(posedge clk) disable iff (!resetn) $onehot0(start_q));
    a_start_only_in_run: assert property (@(posedge clk) disable iff (!resetn)
        (start_q != '0) |-> (state_q == S_RUN));

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: reactive client models, a transaction-level service planner
// and a scoreboard monitor that checks every start grant, pixel write and frame_done.
module tb_draw_sequencer;

    localparam int NC = 4;
    localparam int XW = 9;
    localparam int YW = 9;
    localparam int CW = 3;
    localparam int TO = 90;

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    typedef struct {
        int client;
        int len;
        bit hang;
    } svc_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic [NC-1:0]     req = '0;
    logic [NC-1:0]     start;
    logic [NC-1:0]     client_done;
    logic [NC-1:0]     done_r;
    logic [NC*XW-1:0]  client_x;
    logic [NC*YW-1:0]  client_y;
    logic [NC*CW-1:0]  client_colour;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_colour;
    logic              vga_plot;
    logic              busy;
    logic              frame_done;
    logic              timeout_err;

    int   checks = 0;
    int   failures = 0;
    int   npix[NC];
    bit   hang[NC];
    bit   stray[NC];
    int   base_x[NC];
    int   base_y[NC];
    int   cnt[NC];
    pix_t exp_pix[$];
    svc_t exp_svc[$];
    int   svc_started = 0;
    int   fd_cnt = 0;

    always #5 clk = ~clk;

    assign client_done = done_r;

    draw_sequencer #(
        .NUM_CLIENTS(NC), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .req(req), .start(start), .client_done(client_done),
        .client_x(client_x), .client_y(client_y), .client_colour(client_colour),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic pix_t pix(input int i, input int k);
        pix_t p;
        p.x = XW'(base_x[i] + k);
        p.y = YW'(base_y[i] + 3 * k);
        p.c = CW'(3 * i + k);
        return p;
    endfunction

    // Client model: registered behaviour, one pixel per cycle after seeing start, then done.
    initial begin
        logic [NC-1:0] snap;
        pix_t p;
        done_r = '0;
        client_x = '0;
        client_y = '0;
        client_colour = '0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            snap = start;
            @(posedge clk);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (!resetn) begin
                    cnt[i] = 0;
                    done_r[i] = 1'b0;
                end else if (snap[i]) begin
                    if (!done_r[i]) begin
                        if (!hang[i] && cnt[i] == npix[i]) begin
                            done_r[i] = 1'b1;
                        end else begin
                            p = pix(i, cnt[i]);
                            client_x[i*XW +: XW] = p.x;
                            client_y[i*YW +: YW] = p.y;
                            client_colour[i*CW +: CW] = p.c;
                            cnt[i]++;
                        end
                    end
                end else begin
                    cnt[i] = 0;
                    done_r[i] = stray[i] ? 1'($urandom_range(0, 1)) : 1'b0;
                    client_x[i*XW +: XW] = XW'($urandom);
                    client_y[i*YW +: YW] = YW'($urandom);
                    client_colour[i*CW +: CW] = CW'($urandom);
                end
            end
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        logic [NC-1:0] prev_start;
        svc_t cur;
        pix_t e;
        bit   in_svc;
        bit   model_to;
        bit   rel;
        int   run_len;
        prev_start = '0;
        in_svc = 0;
        model_to = 0;
        run_len = 0;
        cur = '{client: 0, len: 0, hang: 0};
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_start = '0;
                in_svc = 0;
                model_to = 0;
                run_len = 0;
            end else begin
                rel = (prev_start != '0) && (start == '0);
                check("start_onehot0", 64'($countones(start) <= 1), 64'(1));
                if (start != '0) check("busy_in_run", busy, 1'b1);
                if (start != '0 && prev_start == '0) begin
                    svc_started++;
                    if (exp_svc.size() == 0) begin
                        check("start_extra", start, '0);
                    end else begin
                        cur = exp_svc.pop_front();
                        check("svc_client", start, NC'(1) << cur.client);
                        in_svc = 1;
                        run_len = 1;
                    end
                end else if (start != '0) begin
                    run_len++;
                    check("start_stable", start, prev_start);
                end else if (rel && in_svc) begin
                    check("run_len", 64'(run_len), 64'(cur.len));
                    if (cur.hang) model_to = 1;
                    in_svc = 0;
                end
                if (vga_plot) begin
                    if (exp_pix.size() == 0) begin
                        check("plot_extra", vga_plot, 1'b0);
                    end else begin
                        e = exp_pix.pop_front();
                        check("pixel", {vga_x, vga_y, vga_colour}, {e.x, e.y, e.c});
                    end
                end
                check("timeout_err", timeout_err, model_to);
                if (rel) check("frame_done_release", frame_done, exp_svc.size() == 0);
                else     check("frame_done_idle", frame_done, 1'b0);
                if (frame_done) fd_cnt++;
                prev_start = start;
            end
        end
    end

    task automatic new_cfg();
        for (int i = 0; i < NC; i++) begin
            npix[i]   = $urandom_range(3, 20);
            hang[i]   = 0;
            stray[i]  = 0;
            base_x[i] = $urandom_range(0, 511);
            base_y[i] = $urandom_range(0, 511);
        end
    endtask

    // Transaction-level plan: lowest pending first, a re-request joins the set during its service.
    task automatic plan_phase(input logic [NC-1:0] init, input bit rr_en, input int rr_idx,
                              input int rr_client);
        logic [NC-1:0] s;
        int idx;
        s = init;
        idx = 0;
        while (s != '0) begin
            int k;
            int n;
            k = 0;
            while (!s[k]) k++;
            s[k] = 1'b0;
            exp_svc.push_back('{client: k, len: hang[k] ? TO : npix[k] + 2, hang: hang[k]});
            n = hang[k] ? TO - 1 : npix[k];
            for (int p = 0; p < n; p++) exp_pix.push_back(pix(k, p));
            if (rr_en && idx == rr_idx) s[rr_client] = 1'b1;
            idx++;
        end
    endtask

    task automatic wait_svc(input int target);
        int n;
        n = 0;
        while (svc_started < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (svc_started < target) check("svc_start_timeout", 64'(svc_started), 64'(target));
    endtask

    task automatic run_phase(input logic [NC-1:0] init, input bit rr_en, input int rr_idx,
                             input int rr_client);
        int fd0;
        int sv0;
        int n;
        plan_phase(init, rr_en, rr_idx, rr_client);
        fd0 = fd_cnt;
        sv0 = svc_started;
        @(posedge clk); #1 req = init;
        @(posedge clk); #1 req = '0;
        if (rr_en) begin
            wait_svc(sv0 + rr_idx + 1);
            repeat (2) @(posedge clk);
            #1 req = NC'(1) << rr_client;
            @(posedge clk); #1 req = '0;
        end
        n = 0;
        while (fd_cnt == fd0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check("phase_frame_done_count", 64'(fd_cnt - fd0), 64'(1));
        check("phase_pixels_left", 64'(exp_pix.size()), 64'(0));
        check("phase_services_left", 64'(exp_svc.size()), 64'(0));
        check("phase_idle_busy", busy, 1'b0);
        for (int i = 0; i < NC; i++) stray[i] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        new_cfg();
        #1 resetn = 1'b0;
        #10;
        check("rst_start", start, '0);
        check("rst_vga_plot", vga_plot, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_vga_x", vga_x, '0);
        check("rst_vga_y", vga_y, '0);
        check("rst_vga_colour", vga_colour, '0);
        @(posedge clk); #3 resetn = 1'b1;
        repeat (2) @(posedge clk);

        new_cfg(); npix[0] = 81;
        run_phase(4'b0001, 0, 0, 0);

        new_cfg();
        run_phase(4'b1010, 0, 0, 0);

        new_cfg(); stray[0] = 1; stray[3] = 1;
        run_phase(4'b0100, 1, 0, 2);

        new_cfg(); npix[3] = TO - 2;
        run_phase(4'b1000, 0, 0, 0);

        new_cfg(); hang[0] = 1;
        run_phase(4'b0101, 0, 0, 0);

        for (int ph = 0; ph < 12; ph++) begin
            logic [NC-1:0] init;
            bit rr_en;
            int rr_idx;
            int rr_c;
            new_cfg();
            init = NC'($urandom_range(1, (1 << NC) - 1));
            for (int i = 0; i < NC; i++) begin
                hang[i] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 7) == 0) npix[i] = TO - 2;
            end
            rr_en = 1'($urandom_range(0, 1));
            rr_idx = $urandom_range(0, $countones(init) - 1);
            rr_c = $urandom_range(0, NC - 1);
            for (int i = 0; i < NC; i++)
                stray[i] = !init[i] && !(rr_en && rr_c == i) && ($urandom_range(0, 1) == 1);
            run_phase(init, rr_en, rr_idx, rr_c);
        end

        begin
            int sv0;
            new_cfg(); npix[1] = 20;
            plan_phase(4'b0110, 0, 0, 0);
            sv0 = svc_started;
            @(posedge clk); #1 req = 4'b0110;
            @(posedge clk); #1 req = '0;
            wait_svc(sv0 + 1);
            repeat (5) @(posedge clk);
            #3 resetn = 1'b0;
            #1;
            check("midrun_rst_start", start, '0);
            check("midrun_rst_vga_plot", vga_plot, 1'b0);
            check("midrun_rst_busy", busy, 1'b0);
            check("midrun_rst_timeout_err", timeout_err, 1'b0);
            exp_pix.delete();
            exp_svc.delete();
            repeat (2) @(posedge clk);
            #3 resetn = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                check("post_rst_no_service", start, '0);
                check("post_rst_idle", busy, 1'b0);
            end
        end

        new_cfg();
        run_phase(4'b1000, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
